// File: rtl/ad_pkg.sv
// Shared definitions for the AD merge block: fx bus address decode and register map.
package ad_pkg;

  localparam int FX_AW   = 22;
  localparam int DEV_W   = 6;
  localparam int HIT_MSB = 21;
  localparam int HIT_LSB = 16;
  localparam int OFF_MSB = 7;
  localparam int OFF_LSB = 0;
  localparam int REG_W   = 8;

  typedef enum logic [REG_W-1:0] {
    REG_CH_EN_LO = 8'h00,
    REG_CH_EN_HI = 8'h01,
    REG_OVF_LO   = 8'h02,
    REG_OVF_HI   = 8'h03,
    REG_LEVEL    = 8'h04,
    REG_DROP     = 8'h05
  } reg_off_e;

  function automatic logic addr_hit(input logic [FX_AW-1:0] addr,
                                    input logic [DEV_W-1:0] dev_id);
    return addr[HIT_MSB:HIT_LSB] == dev_id;
  endfunction

endpackage

// File: rtl/ad_merge_fifo.sv
// Synchronous FIFO carrying {channel, sample} words from the arbiter to the output stream.
module ad_merge_fifo #(
  parameter int W     = 20,
  parameter int DEPTH = 16
) (
  input  logic                       clk_sys,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic [W-1:0]               pop_data,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  logic [W-1:0]     mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign level   = count_q;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // NOTE: the storage array has no reset; only pointers are reset, and the head is
  // forced to zero while empty so the outputs still read 0 out of reset.
  assign pop_data = empty ? '0 : mem[rd_ptr_q];

  always_ff @(posedge clk_sys) begin
    if (do_push) mem[wr_ptr_q] <= push_data;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
    else if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/ad_merge.sv
// Merges NCH AD sample channels into one tagged stream through per-channel hold
// registers, a round-robin arbiter and an output FIFO; fx bus control/status registers.
module ad_merge
  import ad_pkg::*;
#(
  parameter int NCH   = 8,
  parameter int DW    = 16,
  parameter int DEPTH = 16,
  parameter int CW    = 4
) (
  input  logic                clk_sys,
  input  logic                rst,
  input  logic [DEV_W-1:0]    dev_id,
  input  logic [NCH*DW-1:0]   ad_data,
  input  logic [NCH-1:0]      ad_vld,
  output logic [DW-1:0]       m_data,
  output logic [CW-1:0]       m_ch,
  output logic                m_vld,
  input  logic                m_rdy,
  input  logic [FX_AW-1:0]    fx_waddr,
  input  logic                fx_wr,
  input  logic [REG_W-1:0]    fx_data,
  input  logic [FX_AW-1:0]    fx_raddr,
  input  logic                fx_rd,
  output logic [REG_W-1:0]    fx_q
);

  localparam int FW = CW + DW;
  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [15:0] CH_MASK = 16'((32'd1 << NCH) - 32'd1);

  logic [15:0]      ch_en_q, ch_en_d;
  logic [15:0]      ovf_q, ovf_d, ovf_set, ovf_clr;
  logic [7:0]       drop_q, drop_d;
  logic [8:0]       drop_sum;
  logic [4:0]       n_drop;
  logic [NCH-1:0]   pend_q, pend_d;
  logic [DW-1:0]    hold_q [NCH];
  logic [DW-1:0]    hold_d [NCH];
  logic [CW-1:0]    last_q, last_d;
  logic [REG_W-1:0] fx_rdata_q, fx_rdata_d, rdata;

  logic             hi_found, lo_found;
  logic [CW-1:0]    hi_idx, lo_idx;
  logic [DW-1:0]    hi_data, lo_data;
  logic             gnt_vld;
  logic [CW-1:0]    gnt_idx;
  logic [DW-1:0]    gnt_data;

  logic [FW-1:0]    fifo_head;
  logic             fifo_empty, fifo_full;
  logic [LW-1:0]    fifo_level;

  logic             wr_hit, rd_hit;
  logic [REG_W-1:0] wr_off, rd_off;
  logic             unused_addr_bits;

  assign unused_addr_bits = ^{fx_waddr[HIT_LSB-1:OFF_MSB+1], fx_raddr[HIT_LSB-1:OFF_MSB+1]};

  // Round robin: the lowest pending index above the last grant wins, otherwise wrap to
  // the lowest pending index overall.
  // NOTE: every always_comb output gets a default before any branch, so no latch can form.
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    hi_data  = '0;
    lo_found = 1'b0;
    lo_idx   = '0;
    lo_data  = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (pend_q[i]) begin
        lo_found = 1'b1;
        lo_idx   = CW'(i);
        lo_data  = hold_q[i];
        if (CW'(i) > last_q) begin
          hi_found = 1'b1;
          hi_idx   = CW'(i);
          hi_data  = hold_q[i];
        end
      end
    end
    gnt_vld  = lo_found && !fifo_full;
    gnt_idx  = hi_found ? hi_idx : lo_idx;
    gnt_data = hi_found ? hi_data : lo_data;
    last_d   = gnt_vld ? gnt_idx : last_q;
  end

  // A grant frees the hold register in the same cycle, so a simultaneous new sample
  // is accepted rather than counted as an overflow.
  always_comb begin
    pend_d  = pend_q;
    hold_d  = hold_q;
    ovf_set = '0;
    n_drop  = '0;
    for (int k = 0; k < NCH; k++) begin
      if (gnt_vld && gnt_idx == CW'(k)) pend_d[k] = 1'b0;
      if (ad_vld[k] && ch_en_q[k]) begin
        if (!pend_d[k]) begin
          hold_d[k] = ad_data[k*DW +: DW];
          pend_d[k] = 1'b1;
        end else begin
          ovf_set[k] = 1'b1;
          n_drop     = n_drop + 5'd1;
        end
      end
    end
    drop_sum = {1'b0, drop_q} + {4'b0, n_drop};
    drop_d   = drop_sum[8] ? 8'hFF : drop_sum[7:0];
  end

  always_comb begin
    wr_hit  = fx_wr && addr_hit(fx_waddr, dev_id);
    wr_off  = fx_waddr[OFF_MSB:OFF_LSB];
    ch_en_d = ch_en_q;
    ovf_clr = '0;
    if (wr_hit) begin
      case (wr_off)
        REG_CH_EN_LO: ch_en_d[7:0]  = fx_data;
        REG_CH_EN_HI: ch_en_d[15:8] = fx_data;
        REG_OVF_LO:   ovf_clr[7:0]  = fx_data;
        REG_OVF_HI:   ovf_clr[15:8] = fx_data;
        default:      ;
      endcase
    end
    ch_en_d = ch_en_d & CH_MASK;
    // A new overflow wins over a same-cycle write-1-to-clear.
    ovf_d   = ((ovf_q & ~ovf_clr) | ovf_set) & CH_MASK;
  end

  always_comb begin
    rd_hit = fx_rd && addr_hit(fx_raddr, dev_id);
    rd_off = fx_raddr[OFF_MSB:OFF_LSB];
    rdata  = '0;
    case (rd_off)
      REG_CH_EN_LO: rdata = ch_en_q[7:0];
      REG_CH_EN_HI: rdata = ch_en_q[15:8];
      REG_OVF_LO:   rdata = ovf_q[7:0];
      REG_OVF_HI:   rdata = ovf_q[15:8];
      REG_LEVEL:    rdata = 8'(fifo_level);
      REG_DROP:     rdata = drop_q;
      default:      rdata = '0;
    endcase
    fx_rdata_d = rd_hit ? rdata : '0;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      ch_en_q    <= '0;
      ovf_q      <= '0;
      drop_q     <= '0;
      pend_q     <= '0;
      last_q     <= CW'(NCH - 1);
      fx_rdata_q <= '0;
      for (int k = 0; k < NCH; k++) hold_q[k] <= '0;
    end else begin
      ch_en_q    <= ch_en_d;
      ovf_q      <= ovf_d;
      drop_q     <= drop_d;
      pend_q     <= pend_d;
      last_q     <= last_d;
      fx_rdata_q <= fx_rdata_d;
      hold_q     <= hold_d;
    end
  end

  ad_merge_fifo #(
    .W     (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_sys   (clk_sys),
    .rst       (rst),
    .push      (gnt_vld),
    .push_data ({gnt_idx, gnt_data}),
    .pop       (m_vld && m_rdy),
    .pop_data  (fifo_head),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .level     (fifo_level)
  );

  assign m_vld  = !fifo_empty;
  assign m_ch   = fifo_head[FW-1 -: CW];
  assign m_data = fifo_head[DW-1:0];
  assign fx_q   = fx_rdata_q;

endmodule
